// File: rtl/sprite_blit_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sprite_blit_scheduler
// Purpose  : Shares one vga_adapter pixel-write port and the sprite ROM
//            address bus among NUM_REQ requesters. Requesters are granted
//            round-robin. The granted rectangle is rastered one pixel per
//            cycle while the ROM address is driven. x/y/plot are delayed by
//            ROM_LAT cycles so that they line up with the ROM data.
// Ports    : CLOCK_50  - system clock
//            reset     - synchronous, active-low reset
//            req       - level request per requester, held until done
//            req_x0/y0 - packed rectangle origins (9/8 bits per requester)
//            req_w/h   - packed rectangle size (9/8 bits, 0 allowed)
//            grant     - one-hot owner of the port
//            done      - one-cycle completion pulse per requester
//            busy      - high whenever the FSM is not idle
//            rom_addr  - linear sprite address 0..w*h-1
//            rom_sel   - binary index of the owner (ROM output mux select)
//            vga_x/y   - pixel coordinate aligned to ROM data
//            vga_plot  - pixel write strobe aligned to ROM data
// Revision : 1.0 - initial release
// ============================================================================
module sprite_blit_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 2,
    parameter int ADDR_W  = 16,
    parameter int ROM_LAT = 1,
    parameter int SCR_W   = 320,
    parameter int SCR_H   = 240
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*9-1:0] req_x0,
    input  logic [NUM_REQ*8-1:0] req_y0,
    input  logic [NUM_REQ*9-1:0] req_w,
    input  logic [NUM_REQ*8-1:0] req_h,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic                 busy,
    output logic [ADDR_W-1:0]    rom_addr,
    output logic [SEL_W-1:0]     rom_sel,
    output logic [8:0]           vga_x,
    output logic [7:0]           vga_y,
    output logic                 vga_plot
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ARB   = 3'd1;
    localparam logic [2:0] c_SCAN  = 3'd2;
    localparam logic [2:0] c_FLUSH = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]         r_state;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   r_win;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic [8:0]         r_x0;
    logic [7:0]         r_y0;
    logic [8:0]         r_w;
    logic [7:0]         r_h;
    logic [8:0]         r_cx;
    logic [7:0]         r_cy;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_abort;
    logic [1:0]         r_flush;

    // Pixel delay pipe; the last stage drives the VGA outputs.
    logic [8:0]         r_px [ROM_LAT];
    logic [7:0]         r_py [ROM_LAT];
    logic               r_pv [ROM_LAT];

    logic               w_found;
    logic [SEL_W-1:0]   w_win;
    logic [SEL_W-1:0]   w_cand;
    logic [8:0]         w_wx0;
    logic [7:0]         w_wy0;
    logic [8:0]         w_ww;
    logic [7:0]         w_wh;
    logic [9:0]         w_sx;
    logic [8:0]         w_sy;
    logic               w_valid_in;
    logic               w_last_col;
    logic               w_last_row;
    logic               w_owner_req;

    function automatic logic [SEL_W-1:0] f_wrap(input int k);
        return (k >= NUM_REQ) ? SEL_W'(k - NUM_REQ) : SEL_W'(k);
    endfunction

    // Round-robin: first set request at or after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = f_wrap(int'(r_ptr) + i);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_wx0 = req_x0[int'(w_win)*9 +: 9];
    assign w_wy0 = req_y0[int'(w_win)*8 +: 8];
    assign w_ww  = req_w [int'(w_win)*9 +: 9];
    assign w_wh  = req_h [int'(w_win)*8 +: 8];

    // One extra bit on each sum so that coordinates past the screen edge
    // are clipped rather than wrapped back on screen.
    assign w_sx       = {1'b0, r_x0} + {1'b0, r_cx};
    assign w_sy       = {1'b0, r_y0} + {1'b0, r_cy};
    assign w_valid_in = (r_state == c_SCAN) && (w_sx < 10'(SCR_W)) && (w_sy < 9'(SCR_H));
    assign w_last_col = (r_cx == r_w - 9'd1);
    assign w_last_row = (r_cy == r_h - 8'd1);
    assign w_owner_req = |(req & r_grant);

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_x0    <= '0;
            r_y0    <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_addr  <= '0;
            r_abort <= 1'b0;
            r_flush <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                r_px[i] <= '0;
                r_py[i] <= '0;
                r_pv[i] <= 1'b0;
            end
        end else begin
            r_done  <= '0;
            r_px[0] <= w_sx[8:0];
            r_py[0] <= w_sy[7:0];
            r_pv[0] <= w_valid_in;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_px[i] <= r_px[i-1];
                r_py[i] <= r_py[i-1];
                r_pv[i] <= r_pv[i-1];
            end

            case (r_state)
                c_IDLE: begin
                    if (|req) begin
                        r_state <= c_ARB;
                    end
                end
                c_ARB: begin
                    if (w_found) begin
                        r_grant <= NUM_REQ'(1) << w_win;
                        r_win   <= w_win;
                        r_x0    <= w_wx0;
                        r_y0    <= w_wy0;
                        r_w     <= w_ww;
                        r_h     <= w_wh;
                        r_cx    <= '0;
                        r_cy    <= '0;
                        r_addr  <= '0;
                        r_abort <= 1'b0;
                        r_ptr   <= (w_win == SEL_W'(NUM_REQ - 1)) ? '0 : w_win + SEL_W'(1);
                        if (w_ww == 9'd0 || w_wh == 8'd0) begin
                            r_done  <= NUM_REQ'(1) << w_win;
                            r_state <= c_DONE;
                        end else begin
                            r_state <= c_SCAN;
                        end
                    end else begin
                        // Request withdrawn between IDLE and ARB.
                        r_state <= c_IDLE;
                    end
                end
                c_SCAN: begin
                    // The current pixel is still issued; only the address
                    // stops advancing once the owner withdraws.
                    if (!w_owner_req) begin
                        r_abort <= 1'b1;
                        r_flush <= '0;
                        r_state <= c_FLUSH;
                    end else if (w_last_col && w_last_row) begin
                        r_flush <= '0;
                        r_state <= c_FLUSH;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                        if (w_last_col) begin
                            r_cx <= '0;
                            r_cy <= r_cy + 8'd1;
                        end else begin
                            r_cx <= r_cx + 9'd1;
                        end
                    end
                end
                c_FLUSH: begin
                    if (r_flush == 2'(ROM_LAT - 1)) begin
                        if (r_abort) begin
                            r_grant <= '0;
                            r_win   <= '0;
                            r_state <= c_IDLE;
                        end else begin
                            r_done  <= r_grant;
                            r_state <= c_DONE;
                        end
                    end else begin
                        r_flush <= r_flush + 2'd1;
                    end
                end
                c_DONE: begin
                    r_grant <= '0;
                    r_win   <= '0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign grant    = r_grant;
    assign done     = r_done;
    assign busy     = (r_state != c_IDLE);
    assign rom_addr = r_addr;
    assign rom_sel  = r_win;
    assign vga_x    = r_px[ROM_LAT-1];
    assign vga_y    = r_py[ROM_LAT-1];
    assign vga_plot = r_pv[ROM_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_sprite_blit_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sprite_blit_scheduler
// Purpose  : Scoreboard bench. Two schedulers (ROM_LAT 1 and 2) share the
//            region inputs; each has its own request vector so that every
//            requester can drop its request right after its own done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_blit_scheduler;

    localparam int NR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [NR-1:0] req_v [2];
    logic [35:0]   rx0;
    logic [31:0]   ry0;
    logic [35:0]   rw;
    logic [31:0]   rh;

    logic [NR-1:0] grant [2];
    logic [NR-1:0] done  [2];
    logic          busy  [2];
    logic [15:0]   addr  [2];
    logic [1:0]    sel   [2];
    logic [8:0]    vx    [2];
    logic [7:0]    vy    [2];
    logic          plot  [2];

    sprite_blit_scheduler #(.ROM_LAT(1)) u_dut_l1 (
        .CLOCK_50(clk), .reset(rst_n), .req(req_v[0]),
        .req_x0(rx0), .req_y0(ry0), .req_w(rw), .req_h(rh),
        .grant(grant[0]), .done(done[0]), .busy(busy[0]), .rom_addr(addr[0]),
        .rom_sel(sel[0]), .vga_x(vx[0]), .vga_y(vy[0]), .vga_plot(plot[0])
    );

    sprite_blit_scheduler #(.ROM_LAT(2)) u_dut_l2 (
        .CLOCK_50(clk), .reset(rst_n), .req(req_v[1]),
        .req_x0(rx0), .req_y0(ry0), .req_w(rw), .req_h(rh),
        .grant(grant[1]), .done(done[1]), .busy(busy[1]), .rom_addr(addr[1]),
        .rom_sel(sel[1]), .vga_x(vx[1]), .vga_y(vy[1]), .vga_plot(plot[1])
    );

    int          checks   = 0;
    int          failures = 0;
    logic [16:0] pq [2][$];
    int          gq [2][$];
    int          dq [2][$];
    logic [NR-1:0] prev_g [2];
    int          t_done [2][NR];
    int          t_plot [2];
    int          last_cyc;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------- monitor
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (plot[d] === 1'b1) begin
                if (pq[d].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL plot_extra dut%0d actual x=%0d y=%0d required no plot", d, vx[d], vy[d]);
                end else begin
                    logic [16:0] e;
                    e = pq[d].pop_front();
                    chk($sformatf("pixel_xy dut%0d (x*256+y)", d), longint'({vx[d], vy[d]}), longint'(e));
                end
            end
            if (done[d] !== '0 && done[d] !== 'x) begin
                if (dq[d].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_extra dut%0d actual=%b required none", d, done[d]);
                end else begin
                    int e;
                    e = dq[d].pop_front();
                    chk($sformatf("done_onehot dut%0d", d), longint'(done[d]), longint'(1 << e));
                end
            end
            if (grant[d] !== '0 && grant[d] !== 'x && grant[d] !== prev_g[d]) begin
                if (gq[d].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL grant_extra dut%0d actual=%b required none", d, grant[d]);
                end else begin
                    int e;
                    e = gq[d].pop_front();
                    chk($sformatf("grant_sel dut%0d", d), longint'({grant[d], sel[d]}),
                        longint'({4'(1 << e), 2'(e)}));
                end
            end
            prev_g[d] = grant[d];
        end
    end

    // ------------------------------------------------------------- helpers
    task automatic set_reg(input int i, input int x0, input int y0, input int w, input int h);
        rx0[i*9 +: 9] = 9'(x0);
        ry0[i*8 +: 8] = 8'(y0);
        rw [i*9 +: 9] = 9'(w);
        rh [i*8 +: 8] = 8'(h);
    endtask

    // Expected plots of a raster, limited to the first 'limit' addresses.
    task automatic push_pix(input int d, input int x0, input int y0, input int w, input int h,
                            input int limit);
        int n = 0;
        for (int cy = 0; cy < h; cy++) begin
            for (int cx = 0; cx < w; cx++) begin
                if (n < limit && (x0 + cx) < 320 && (y0 + cy) < 240)
                    pq[d].push_back({9'(x0 + cx), 8'(y0 + cy)});
                n++;
            end
        end
    endtask

    task automatic expect_blit(input int i, input int x0, input int y0, input int w, input int h);
        for (int d = 0; d < 2; d++) begin
            push_pix(d, x0, y0, w, h, 1 << 30);
            gq[d].push_back(i);
            dq[d].push_back(i);
        end
    endtask

    task automatic raise(input int i);
        req_v[0][i] = 1'b1;
        req_v[1][i] = 1'b1;
    endtask

    // Runs until both schedulers are idle and no request is left; each
    // requester drops its request at its own done pulse.
    task automatic run(input int budget);
        int  cyc   = 0;
        bit  quiet = 1'b0;
        for (int d = 0; d < 2; d++) begin
            t_plot[d] = -1;
            for (int i = 0; i < NR; i++) t_done[d][i] = -1;
        end
        while (!quiet && cyc < budget) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (plot[d] && t_plot[d] < 0) t_plot[d] = cyc;
                for (int i = 0; i < NR; i++) begin
                    if (done[d][i]) begin
                        req_v[d][i] = 1'b0;
                        if (t_done[d][i] < 0) t_done[d][i] = cyc;
                    end
                end
            end
            quiet = (req_v[0] == '0) && (req_v[1] == '0) && !busy[0] && !busy[1];
        end
        last_cyc = cyc;
        chk("run_completes_in_budget", longint'(quiet), 1);
    endtask

    task automatic wait_addr(input int val, input int budget);
        int n = 0;
        while (addr[0] != 16'(val) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_addr_reached", longint'(addr[0]), longint'(val));
        chk("wait_addr_dut_aligned", longint'(addr[1]), longint'(val));
    endtask

    task automatic chk_zero(input string name);
        for (int d = 0; d < 2; d++)
            chk($sformatf("%s dut%0d", name, d),
                longint'({grant[d], done[d], busy[d], addr[d], sel[d], vx[d], vy[d], plot[d]}), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        rst_n    = 1'b0;
        req_v[0] = '0;
        req_v[1] = '0;
        rx0 = '0; ry0 = '0; rw = '0; rh = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset_outputs");
        rst_n = 1'b1;

        // Abort: owner 0 drops at pixel 100, pending requester 1 follows.
        set_reg(0, 0, 0, 50, 10);
        set_reg(1, 200, 100, 4, 3);
        for (int d = 0; d < 2; d++) begin
            push_pix(d, 0, 0, 50, 10, 101);
            gq[d].push_back(0);
        end
        expect_blit(1, 200, 100, 4, 3);
        @(negedge clk);
        raise(0);
        raise(1);
        wait_addr(100, 2000);
        req_v[0][0] = 1'b0;
        req_v[1][0] = 1'b0;
        run(2000);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("abort_no_done0 dut%0d", d), t_done[d][0], -1);
            chk($sformatf("abort_final_addr dut%0d", d), longint'(addr[d]), 11);
        end

        // Round-robin from pointer 0: 1 then 3, then 0 then 1.
        do_reset();
        set_reg(1, 5, 5, 3, 2);
        set_reg(3, 100, 50, 2, 2);
        expect_blit(1, 5, 5, 3, 2);
        expect_blit(3, 100, 50, 2, 2);
        raise(1);
        raise(3);
        run(500);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rr_first_plot_lat dut%0d", d), t_plot[d], 2 + (d + 1));
            chk($sformatf("rr_done1_lat dut%0d", d), t_done[d][1], 6 + (d + 1) + 2);
        end
        set_reg(0, 20, 30, 2, 3);
        set_reg(1, 40, 40, 3, 1);
        expect_blit(0, 20, 30, 2, 3);
        expect_blit(1, 40, 40, 3, 1);
        raise(0);
        raise(1);
        run(500);

        // Zero width on requester 2.
        set_reg(2, 50, 50, 0, 7);
        expect_blit(2, 50, 50, 0, 7);
        raise(2);
        run(100);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("zero_w_done_lat dut%0d", d), t_done[d][2], 2);
            chk($sformatf("zero_w_no_plot dut%0d", d), t_plot[d], -1);
        end
        chk("zero_w_idle_cycle", last_cyc, 3);

        // Clipped region straddling the bottom-right corner.
        set_reg(3, 310, 235, 20, 10);
        expect_blit(3, 310, 235, 20, 10);
        raise(3);
        run(1000);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("clip_final_addr dut%0d", d), longint'(addr[d]), 199);
            chk($sformatf("clip_first_plot_lat dut%0d", d), t_plot[d], 2 + (d + 1));
            chk($sformatf("clip_done_lat dut%0d", d), t_done[d][3], 200 + (d + 1) + 2);
        end

        // Large region on requester 0.
        set_reg(0, 0, 75, 320, 165);
        expect_blit(0, 0, 75, 320, 165);
        raise(0);
        run(60000);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("big_final_addr dut%0d", d), longint'(addr[d]), 52799);
            chk($sformatf("big_first_plot_lat dut%0d", d), t_plot[d], 2 + (d + 1));
            chk($sformatf("big_done_lat dut%0d", d), t_done[d][0], 52800 + (d + 1) + 2);
        end

        // Reset during SCAN of requester 3 while requester 0 also waits.
        set_reg(3, 10, 10, 20, 20);
        set_reg(0, 0, 0, 2, 2);
        for (int d = 0; d < 2; d++) begin
            gq[d].push_back(3);
            push_pix(d, 10, 10, 20, 20, (d == 0) ? 50 : 49);
        end
        expect_blit(0, 0, 0, 2, 2);
        expect_blit(3, 10, 10, 20, 20);
        @(negedge clk);
        raise(3);
        wait_addr(50, 500);
        raise(0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("midscan_reset_outputs");
        rst_n = 1'b1;
        run(2000);

        for (int d = 0; d < 2; d++) begin
            chk($sformatf("pixels_left dut%0d", d), pq[d].size(), 0);
            chk($sformatf("grants_left dut%0d", d), gq[d].size(), 0);
            chk($sformatf("dones_left dut%0d", d), dq[d].size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
